div_seq: RTL and testbench

//  Multi-cycle 32-bit signed/unsigned divider sequencer serving the EX stage for DIV/DIVU.

---
 rtl/div_seq_pkg.sv | 20 ++
 rtl/div_seq.sv | 134 +++++++++++++
 tb/tb_div_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the multi-cycle DIV/DIVU sequencer.
package div_seq_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [DIV_DATA_W-1:0] neg_if(input logic                  en,
                                                   input logic [DIV_DATA_W-1:0] val);
    return en ? -val : val;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per clock, 64-bit
// {remainder, quotient} result handed to the HI/LO write path.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q;
  logic                q_neg_q, r_neg_q;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;
  logic                load;

  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   op1_abs, op2_abs, quot, rem;

  assign op1_abs = neg_if(signed_div_i & opdata1_i[DATA_W-1], opdata1_i);
  assign op2_abs = neg_if(signed_div_i & opdata2_i[DATA_W-1], opdata2_i);

  // Trial subtraction of the divisor from the partial remainder plus next bit.
  assign diff = dividend_q[2*DATA_W:DATA_W] - {1'b0, divisor_q};

  assign quot = neg_if(q_neg_q, dividend_q[DATA_W-1:0]);
  assign rem  = neg_if(r_neg_q, dividend_q[2*DATA_W:DATA_W+1]);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    result_d   = result_o;
    ready_d    = ready_o;
    load       = 1'b0;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{DATA_W{1'b0}}, op1_abs, 1'b0};
            load       = 1'b1;
          end
        end
      end

      DIV_BY_ZERO: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = 1'b0;
        end else begin
          state_d = DIV_END;
          ready_d = 1'b1;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          if (diff[DATA_W]) begin
            dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_d = {diff[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DIV_END;
          result_d = {rem, quot};
          ready_d  = 1'b1;
        end
      end

      DIV_END: begin
        if (!start_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      result_o   <= result_d;
      ready_o    <= ready_d;
    end
  end

  // NOTE: the operand latches carry no reset; they are only read after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      divisor_q <= op2_abs;
      q_neg_q   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
      r_neg_q   <= signed_div_i & opdata1_i[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases, aborts, reset and
// randomized divides against an arithmetic reference model.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks;
  int errors;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: plain language-level division, {remainder, quotient}.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    tick();
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset: ready_o=%b result_o=%h expected 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_division(input string name, input bit sgn, input logic [31:0] a,
                               input logic [31:0] b);
    logic [63:0] exp_res;
    int          exp_lat;
    int          n;
    exp_res = ref_div(sgn, a, b);
    exp_lat = (b == 32'd0) ? 1 : 33;
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; annul_i = 1'b0; start_i = 1'b1;
    tick();
    // Operands are sampled only at acceptance; scramble them afterwards.
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom_range(0, 1));
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s early_ready: ready_o=%b expected 0 after E0", name, ready_o);
    end
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (ready_o === 1'b1) break;
    end
    checks++;
    if (n != exp_lat || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: ready after %0d edges (ready_o=%b) expected %0d", name, n, ready_o, exp_lat);
    end
    checks++;
    if (result_o !== exp_res) begin
      errors++;
      $display("FAIL %s result: op %h/%h sgn=%0d got %h expected %h", name, a, b, sgn, result_o, exp_res);
    end
    tick();
    checks++;
    if (ready_o !== 1'b1 || result_o !== exp_res) begin
      errors++;
      $display("FAIL %s hold: ready_o=%b result_o=%h expected 1/%h", name, ready_o, result_o, exp_res);
    end
    start_i = 1'b0;
    tick();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL %s release: ready_o=%b result_o=%h expected 0/0", name, ready_o, result_o);
    end
  endtask

  task automatic test_directed();
    test_division("divu_100_7", 1'b0, 32'd100, 32'd7);
    test_division("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    test_division("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    test_division("div_5_0", 1'b1, 32'd5, 32'd0);
    test_division("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    test_division("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    test_division("divu_small_big", 1'b0, 32'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_annul();
    bit seen;
    signed_div_i = 1'b0; opdata1_i = $urandom; opdata2_i = 32'd5; annul_i = 1'b0; start_i = 1'b1;
    tick();
    repeat (9) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ready_o !== 1'b0 || result_o !== 64'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL annul_div_on: ready_o/result_o became nonzero (now %b/%h) expected 0/0", ready_o, result_o);
    end
    test_division("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3);

    // Abort a divide-by-zero before it reports.
    signed_div_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      if (ready_o !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL annul_by_zero: ready_o=%b expected 0", ready_o);
    end
  endtask

  task automatic test_start_with_annul();
    bit seen;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    start_i = 1'b1; annul_i = 1'b1;
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL start_with_annul: ready_o asserted, expected request rejected");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    signed_div_i = 1'b1; opdata1_i = 32'd12345; opdata2_i = 32'd17; annul_i = 1'b0; start_i = 1'b1;
    tick();
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ready_o !== 1'b0 || result_o !== 64'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid: ready_o/result_o nonzero after reset (now %b/%h) expected 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit          sgn;
    for (int i = 0; i < 30; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      test_division("random", sgn, a, b);
    end
  endtask

  initial begin
    clk = 1'b0;
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_annul();
    test_start_with_annul();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
